// File: rtl/lf_pkg.sv
// Shared types, default constants and range-limiting helpers for the TDC loop filter.
// Optional build macro used by the filter: LF_FREEZE_EN.
package lf_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } lf_state_t;

    localparam int LF_DIN_WIDTH    = 7;
    localparam int LF_ACC_WIDTH    = 20;
    localparam int LF_OUT_WIDTH    = 12;
    localparam int LF_OUT_CENTER   = 2048;
    localparam int LF_KI_SHIFT     = 4;
    localparam int LF_KP_SHIFT_ACQ = 4;
    localparam int LF_KP_SHIFT_TRK = 2;
    localparam int LF_LOCK_THRESH  = 3;
    localparam int LF_LOCK_COUNT   = 16;
    localparam int LF_UNLOCK_COUNT = 4;

    // Limit x to the range of a w-bit two's complement number; caller truncates to w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Limit x to [0, 2^w-1]; caller truncates to w bits.
    function automatic logic signed [63:0] clamp_unsigned(input logic signed [63:0] x,
                                                          input int unsigned w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< w) - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < 64'sd0) begin
            return 64'sd0;
        end
        return x;
    endfunction

endpackage

// File: rtl/lf_lock_detect.sv
// Lock detector: counts consecutive in/out-of-window samples and selects the gain gear.
//   state   | meaning
//   ACQUIRE | high proportional gain, counting in-window samples toward lock
//   TRACK   | low proportional gain, counting out-of-window samples toward unlock
module lf_lock_detect
    import lf_pkg::*;
#(
    parameter int DIN_WIDTH    = LF_DIN_WIDTH,
    parameter int LOCK_THRESH  = LF_LOCK_THRESH,
    parameter int LOCK_COUNT   = LF_LOCK_COUNT,
    parameter int UNLOCK_COUNT = LF_UNLOCK_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 hold_i,
    input  logic [DIN_WIDTH:0]   e_abs_i,
    output lf_state_t            state_o,
    output logic                 locked_o
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   LOCK_V   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]   UNLOCK_V = CNT_W'(UNLOCK_COUNT);
    localparam logic [DIN_WIDTH:0] THRESH_V = (DIN_WIDTH + 1)'(LOCK_THRESH);

    lf_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_win;

    assign in_win  = (e_abs_i <= THRESH_V);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQUIRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (valid_i && !hold_i) begin
            case (state_q)
                ACQUIRE: begin
                    if (!in_win) begin
                        cnt_d = '0;
                    end else if (cnt_inc == LOCK_V) begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                TRACK: begin
                    if (in_win) begin
                        cnt_d = '0;
                    end else if (cnt_inc == UNLOCK_V) begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    assign state_o  = state_q;
    assign locked_o = (state_q == TRACK);

endmodule

// File: rtl/tdc_loop_filter.sv
// PI loop filter between TDC and DCO: saturating integrator plus geared proportional path.
// Build macro LF_FREEZE_EN adds lf_freeze, which holds the integrator and lock state.
module tdc_loop_filter
    import lf_pkg::*;
#(
    parameter int DIN_WIDTH    = LF_DIN_WIDTH,
    parameter int ACC_WIDTH    = LF_ACC_WIDTH,
    parameter int OUT_WIDTH    = LF_OUT_WIDTH,
    parameter int OUT_CENTER   = LF_OUT_CENTER,
    parameter int KI_SHIFT     = LF_KI_SHIFT,
    parameter int KP_SHIFT_ACQ = LF_KP_SHIFT_ACQ,
    parameter int KP_SHIFT_TRK = LF_KP_SHIFT_TRK,
    parameter int LOCK_THRESH  = LF_LOCK_THRESH,
    parameter int LOCK_COUNT   = LF_LOCK_COUNT,
    parameter int UNLOCK_COUNT = LF_UNLOCK_COUNT
) (
    input  logic                 Clk_ref,
    input  logic                 Rst,
`ifdef LF_FREEZE_EN
    input  logic                 lf_freeze,
`endif
    input  logic [DIN_WIDTH-1:0] tdc_err,
    input  logic                 tdc_valid,
    output logic [OUT_WIDTH-1:0] dco_word,
    output logic                 dco_valid,
    output logic                 locked
);

    localparam int RAW_W = ACC_WIDTH + 2;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0]        dco_word_q, dco_word_d;
    logic                        dco_valid_q;

    logic                        freeze;
    lf_state_t                   state;
    logic signed [DIN_WIDTH:0]   e_sx;
    logic [DIN_WIDTH:0]          e_abs;
    logic signed [RAW_W-1:0]     e_wide;
    logic signed [RAW_W-1:0]     acc_sum;
    logic signed [RAW_W-1:0]     prop;
    logic signed [RAW_W-1:0]     integ;
    logic signed [RAW_W-1:0]     raw;
    int                          kp;

`ifdef LF_FREEZE_EN
    assign freeze = lf_freeze;
`else
    assign freeze = 1'b0;
`endif

    // One extra bit so that the most negative sample has a representable magnitude.
    assign e_sx   = $signed({tdc_err[DIN_WIDTH-1], tdc_err});
    assign e_abs  = e_sx[DIN_WIDTH] ? $unsigned(-e_sx) : $unsigned(e_sx);
    assign e_wide = RAW_W'(e_sx);

    always_comb begin
        acc_sum    = RAW_W'(acc_q) + e_wide;
        acc_d      = freeze ? acc_q
                            : ACC_WIDTH'(sat_signed(64'(acc_sum), ACC_WIDTH));
        kp         = (state == TRACK) ? KP_SHIFT_TRK : KP_SHIFT_ACQ;
        prop       = e_wide <<< kp;
        integ      = RAW_W'(acc_d) >>> KI_SHIFT;
        raw        = RAW_W'(OUT_CENTER) + prop + integ;
        dco_word_d = OUT_WIDTH'(clamp_unsigned(64'(raw), OUT_WIDTH));
    end

    always_ff @(posedge Clk_ref) begin
        if (Rst) begin
            acc_q       <= '0;
            dco_word_q  <= OUT_WIDTH'(OUT_CENTER);
            dco_valid_q <= 1'b0;
        end else if (tdc_valid) begin
            acc_q       <= acc_d;
            dco_word_q  <= dco_word_d;
            dco_valid_q <= 1'b1;
        end else begin
            dco_valid_q <= 1'b0;
        end
    end

    lf_lock_detect #(
        .DIN_WIDTH    (DIN_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock (
        .clk      (Clk_ref),
        .rst      (Rst),
        .valid_i  (tdc_valid),
        .hold_i   (freeze),
        .e_abs_i  (e_abs),
        .state_o  (state),
        .locked_o (locked)
    );

    assign dco_word  = dco_word_q;
    assign dco_valid = dco_valid_q;

endmodule

// File: tb/tb_tdc_loop_filter.sv
// Directed bench for tdc_loop_filter with hand-computed expected DCO words and lock status.
module tb_tdc_loop_filter;

    logic        Clk_ref;
    logic        Rst;
    logic [6:0]  tdc_err;
    logic        tdc_valid;
    logic [11:0] dco_word;
    logic        dco_valid;
    logic        locked;

    int checks = 0;
    int errors = 0;

    tdc_loop_filter dut (
        .Clk_ref   (Clk_ref),
        .Rst       (Rst),
        .tdc_err   (tdc_err),
        .tdc_valid (tdc_valid),
        .dco_word  (dco_word),
        .dco_valid (dco_valid),
        .locked    (locked)
    );

    initial Clk_ref = 1'b0;
    always #5 Clk_ref = ~Clk_ref;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk_ref);
        Rst       = 1'b1;
        tdc_valid = 1'b0;
        tdc_err   = '0;
        @(negedge Clk_ref);
        Rst = 1'b0;
    endtask

    // Presents one sample for one edge; returns at the following negedge.
    task automatic send(input int e);
        @(negedge Clk_ref);
        tdc_err   = 7'(e);
        tdc_valid = 1'b1;
        @(negedge Clk_ref);
        tdc_valid = 1'b0;
    endtask

    task automatic stream(input int e, input int n);
        @(negedge Clk_ref);
        tdc_err   = 7'(e);
        tdc_valid = 1'b1;
        repeat (n) @(negedge Clk_ref);
        tdc_valid = 1'b0;
    endtask

    initial begin
        Rst       = 1'b1;
        tdc_valid = 1'b0;
        tdc_err   = '0;
        repeat (2) @(negedge Clk_ref);
        Rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge Clk_ref);
            check("idle_word",   longint'(dco_word), 2048);
            check("idle_valid",  longint'(dco_valid), 0);
            check("idle_locked", longint'(locked), 0);
        end

        // +20 in ACQUIRE: 2048 + 20*16 + (20>>>4)
        send(20);
        check("p20_word",  longint'(dco_word), 2369);
        check("p20_valid", longint'(dco_valid), 1);
        check("p20_acc",   longint'(dut.acc_q), 20);
        @(negedge Clk_ref);
        check("p20_valid_drop", longint'(dco_valid), 0);
        check("p20_word_hold",  longint'(dco_word), 2369);

        // -1 from reset: flooring shift gives -1 from the integrator
        do_reset();
        send(-1);
        check("m1_word", longint'(dco_word), 2031);
        check("m1_acc",  longint'(dut.acc_q), -1);

        // Lock acquisition with e=+2
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            send(2);
            check("acq_word", longint'(dco_word), 2048 + 32 + ((2 * k) >>> 4));
        end
        check("pre_lock", longint'(locked), 0);
        send(2);
        check("lock_word", longint'(dco_word), 2082);
        check("lock_rise", longint'(locked), 1);
        send(2);
        check("trk_gain_word", longint'(dco_word), 2058);

        // Three out-of-window samples then one in-window: stays locked
        send(10);
        check("trk_o1_word", longint'(dco_word), 2090);
        send(10);
        send(10);
        check("trk_o3_word",   longint'(dco_word), 2092);
        check("trk_o3_locked", longint'(locked), 1);
        send(0);
        check("trk_brk_word",   longint'(dco_word), 2052);
        check("trk_brk_locked", longint'(locked), 1);

        // Four consecutive out-of-window samples drop lock
        send(10);
        check("unl1_word", longint'(dco_word), 2092);
        send(10);
        send(10);
        check("unl3_locked", longint'(locked), 1);
        send(10);
        check("unl4_word",   longint'(dco_word), 2094);
        check("unl4_locked", longint'(locked), 0);
        send(10);
        check("reacq_word", longint'(dco_word), 2215);

        // Boundary of the lock window: +3 counts, +4 resets the run
        do_reset();
        for (int k = 0; k < 15; k++) send(3);
        send(4);
        send(3);
        check("win_edge_locked", longint'(locked), 0);

        // Reset while locked and a sample is presented
        do_reset();
        for (int k = 0; k < 16; k++) send(2);
        check("rst_pre_locked", longint'(locked), 1);
        @(negedge Clk_ref);
        tdc_err   = 7'd5;
        tdc_valid = 1'b1;
        Rst       = 1'b1;
        @(negedge Clk_ref);
        check("rst_word",   longint'(dco_word), 2048);
        check("rst_locked", longint'(locked), 0);
        check("rst_valid",  longint'(dco_valid), 0);
        check("rst_acc",    longint'(dut.acc_q), 0);
        Rst       = 1'b0;
        tdc_valid = 1'b0;

        // Positive saturation of integrator and output
        do_reset();
        stream(63, 8400);
        check("sat_hi_acc",    longint'(dut.acc_q), 524287);
        check("sat_hi_word",   longint'(dco_word), 4095);
        check("sat_hi_locked", longint'(locked), 0);

        // Negative: first sample 2048 - 1024 - 4, then output clamps at 0
        do_reset();
        send(-64);
        check("neg1_word", longint'(dco_word), 1020);
        do_reset();
        stream(-64, 300);
        check("sat_lo_acc",  longint'(dut.acc_q), -19200);
        check("sat_lo_word", longint'(dco_word), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_loop_filter.md
Name: tdc_loop_filter

Overview:
- Digital proportional-integral loop filter directly downstream of the TDC in the PLL linear model.
- Consumes one signed phase-error sample per reference cycle and produces a registered, saturated unsigned DCO tuning word.
- A lock-detect FSM switches the proportional gain between an acquisition gear and a tracking gear, and reports lock status.

Parameters:
- DIN_WIDTH, 7, width of the signed TDC error input.
- ACC_WIDTH, 20, width of the signed integrator accumulator.
- OUT_WIDTH, 12, width of the unsigned DCO control word.
- OUT_CENTER, 2048, DCO word produced when proportional and integral terms are both zero.
- KI_SHIFT, 4, integral path gain 2^-KI_SHIFT (arithmetic right shift of the accumulator).
- KP_SHIFT_ACQ, 4, proportional gain 2^KP_SHIFT_ACQ in ACQUIRE.
- KP_SHIFT_TRK, 2, proportional gain 2^KP_SHIFT_TRK in TRACK.
- LOCK_THRESH, 3, in-window limit on |error|.
- LOCK_COUNT, 16, consecutive in-window samples needed to enter TRACK.
- UNLOCK_COUNT, 4, consecutive out-of-window samples needed to return to ACQUIRE.

Ports:
- Clk_ref  in  1  reference clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- tdc_err  in  DIN_WIDTH  signed phase error (TDC Dout).
- tdc_valid  in  1  tdc_err is a new sample this cycle.
- dco_word  out  OUT_WIDTH  unsigned DCO control word.
- dco_valid  out  1  one-cycle pulse: dco_word was updated.
- locked  out  1  high while the FSM is in TRACK.

Behaviour:
- Reset (Rst high at a Clk_ref edge): acc=0, dco_word=OUT_CENTER, dco_valid=0, locked=0, state=ACQUIRE, counter=0. Rst has priority over tdc_valid and aborts any count in progress.
- tdc_valid low: all state holds and dco_valid=0.
- tdc_valid high (sample e, sign-extended):
  - acc_n = acc + e, saturated to [-(2^(ACC_WIDTH-1)), 2^(ACC_WIDTH-1)-1].
  - kp is taken from the state before this edge.
  - raw = OUT_CENTER + (e <<< kp) + (acc_n >>> KI_SHIFT). The shift is arithmetic, so it floors. raw is computed at ACC_WIDTH+2 bits signed.
  - dco_word = raw clamped to [0, 2^OUT_WIDTH-1].
  - acc=acc_n.
  - dco_valid=1 on the next cycle only. Latency is one Clk_ref edge.
- In-window test: |e| <= LOCK_THRESH. |e| is computed at DIN_WIDTH+1 bits, so -64 gives 64.
- FSM, updated on valid samples only:
  - ACQUIRE: in-window increments the counter; out-of-window clears it. When an in-window sample brings the count to LOCK_COUNT, go to TRACK, clear the counter, and set locked=1 on the same edge.
  - TRACK: out-of-window increments the counter; in-window clears it. On reaching UNLOCK_COUNT, go to ACQUIRE, clear the counter, and set locked=0.
- The counter is wide enough for max(LOCK_COUNT, UNLOCK_COUNT) and never wraps.
- Gear switching does not modify acc (bumpless in the integral path).

Optional Feature:
- Macro: LF_FREEZE_EN.
- With the macro defined:
  - Adds input port lf_freeze (1 bit).
  - While lf_freeze=1, valid samples leave acc, FSM and counter unchanged.
  - dco_word is still recomputed as OUT_CENTER + prop + (acc >>> KI_SHIFT).
  - dco_valid still pulses.
- Without the macro: no port, and the filter never freezes.

Decomposition:
- Package lf_pkg holds:
  - typedef lf_state_t enum {ACQUIRE, TRACK};
  - saturate and clamp functions parameterised by width;
  - default gain and threshold constants.
- Sub-module lf_lock_detect holds the FSM, counter and locked output. It takes e_abs and valid as inputs and returns state.
- The top module holds the arithmetic datapath.

Test Plan:
- Reset then idle: dco_word=2048, dco_valid=0 and locked=0 for 10 cycles with tdc_valid=0.
- One sample e=+20 in ACQUIRE: acc=20, dco_word=2048+320+1=2369, dco_valid high exactly one cycle later.
- One sample e=-1 from reset: acc=-1, dco_word=2048-16+(-1)=2031, which checks the flooring shift.
- 16 consecutive e=+2 samples: locked rises on the 16th. The next e=+2 gives prop=8, not 32. Then 4 samples of e=+10 drop locked. A 3-sample run broken by e=0 keeps locked high.
- Repeated e=+63: dco_word clamps at 4095 and acc stops at 524287. Repeated e=-64: dco_word clamps at 0.
- Rst asserted mid-lock with tdc_valid high: the next edge gives dco_word=2048, locked=0, acc=0.
